// File: rtl/dbg_ctx_sequencer.sv
// rtl/dbg_ctx_sequencer.sv - debug-port master: halt core, save/restore/verify a register window, optional resume
//
// Optional feature macro: DBG_SEQ_VERIFY_EN (VERIFY op, mismatch comparator and counter).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake; cmd_op_i (0 SAVE, 1 RESTORE, 2 VERIFY), cmd_resume_i
//   done_o, error_o               registered one-cycle completion pulse and its error flag
//   mismatch_cnt_o                VERIFY mismatches of the last command (saturating)
//   ctx_idx_i/ctx_we_i/ctx_wdata_i/ctx_rdata_o   external context buffer port (writes only while idle)
//   debug_req_o/addr_o/we_o/wdata_o, debug_gnt_i/rvalid_i/rdata_i   single-outstanding debug bus
//   debug_halt_o/debug_resume_o/debug_halted_i  core run control
module dbg_ctx_sequencer #(
  parameter int          NUM_REGS    = 32,
  parameter logic [14:0] REG_BASE    = 15'h400,
  parameter int          ADDR_STRIDE = 4,
  parameter int          TIMEOUT     = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic        cmd_resume_i,
  output logic        done_o,
  output logic        error_o,
  output logic [6:0]  mismatch_cnt_o,
  input  logic [5:0]  ctx_idx_i,
  input  logic        ctx_we_i,
  input  logic [31:0] ctx_wdata_i,
  output logic [31:0] ctx_rdata_o,
  output logic        debug_req_o,
  output logic [14:0] debug_addr_o,
  output logic        debug_we_o,
  output logic [31:0] debug_wdata_o,
  input  logic        debug_gnt_i,
  input  logic        debug_rvalid_i,
  input  logic [31:0] debug_rdata_i,
  output logic        debug_halt_o,
  output logic        debug_resume_o,
  input  logic        debug_halted_i
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    LAST_IDX = 6'(NUM_REGS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0]    OP_SAVE = 2'd0, OP_RESTORE = 2'd1, OP_VERIFY = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_REQ, S_WAIT_RV, S_RESUME, S_DONE} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic          resume_q;
  logic          err_q;
  logic [5:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   ctx [64];
  logic          illegal_op;
  logic          progress;
  logic          timeout;
  logic [14:0]   req_addr;

  assign req_addr    = REG_BASE + 15'(idx) * 15'(ADDR_STRIDE);
  assign ctx_rdata_o = ctx[ctx_idx_i];
  // done_o is still high during the first IDLE cycle, which keeps ready low for one more cycle.
  assign cmd_ready_o = (state == S_IDLE) && !done_o && !rst_i;

`ifdef DBG_SEQ_VERIFY_EN
  logic [6:0] mism_q;
  assign mismatch_cnt_o = mism_q;
  assign illegal_op     = (cmd_op_i == 2'd3);
`else
  assign mismatch_cnt_o = 7'd0;
  assign illegal_op     = (cmd_op_i == 2'd3) || (cmd_op_i == OP_VERIFY);
`endif

  // The event each waiting state is waiting for; the shared timeout only fires without it.
  always_comb begin
    progress = 1'b0;
    case (state)
      S_HALT:    progress = debug_halted_i;
      S_REQ:     progress = debug_req_o && debug_gnt_i;
      S_WAIT_RV: progress = debug_rvalid_i;
      S_RESUME:  progress = !debug_halted_i;
      default:   progress = 1'b0;
    endcase
  end

  assign timeout = (state inside {S_HALT, S_REQ, S_WAIT_RV, S_RESUME}) && !progress && (cnt == CNT_LAST);

  // Context buffer: never reset. External writes only land while idle, SAVE data only in WAIT_RV.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_IDLE && ctx_we_i)
        ctx[ctx_idx_i] <= ctx_wdata_i;
      else if (state == S_WAIT_RV && op_q == OP_SAVE && debug_rvalid_i)
        ctx[idx] <= debug_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      op_q           <= 2'd0;
      resume_q       <= 1'b0;
      err_q          <= 1'b0;
      idx            <= 6'd0;
      cnt            <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      debug_req_o    <= 1'b0;
      debug_addr_o   <= 15'd0;
      debug_we_o     <= 1'b0;
      debug_wdata_o  <= 32'd0;
      debug_halt_o   <= 1'b0;
      debug_resume_o <= 1'b0;
`ifdef DBG_SEQ_VERIFY_EN
      mism_q         <= 7'd0;
`endif
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      cnt     <= cnt + 1'b1;
      if (timeout) begin
        // Abandon in place: every debug output drops, the core keeps its current run state.
        state          <= S_DONE;
        err_q          <= 1'b1;
        debug_req_o    <= 1'b0;
        debug_addr_o   <= 15'd0;
        debug_we_o     <= 1'b0;
        debug_wdata_o  <= 32'd0;
        debug_halt_o   <= 1'b0;
        debug_resume_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (cmd_valid_i && cmd_ready_o) begin
              op_q     <= cmd_op_i;
              resume_q <= cmd_resume_i;
              idx      <= 6'd0;
              err_q    <= 1'b0;
`ifdef DBG_SEQ_VERIFY_EN
              mism_q   <= 7'd0;
`endif
              if (illegal_op) begin
                err_q <= 1'b1;
                state <= S_DONE;
              end else if (debug_halted_i) begin
                state <= S_REQ;
              end else begin
                debug_halt_o <= 1'b1;
                state        <= S_HALT;
              end
            end
          end
          S_HALT: begin
            if (debug_halted_i) begin
              debug_halt_o <= 1'b0;
              cnt          <= '0;
              state        <= S_REQ;
            end
          end
          S_REQ: begin
            if (progress) begin
              debug_req_o   <= 1'b0;
              debug_addr_o  <= 15'd0;
              debug_we_o    <= 1'b0;
              debug_wdata_o <= 32'd0;
              cnt           <= '0;
              state         <= S_WAIT_RV;
            end else if (!debug_req_o) begin
              // Request fields are captured once and held until the grant.
              debug_req_o   <= 1'b1;
              debug_addr_o  <= req_addr;
              debug_we_o    <= (op_q == OP_RESTORE);
              debug_wdata_o <= (op_q == OP_RESTORE) ? ctx[idx] : 32'd0;
            end
          end
          S_WAIT_RV: begin
            if (debug_rvalid_i) begin
`ifdef DBG_SEQ_VERIFY_EN
              if (op_q == OP_VERIFY && debug_rdata_i != ctx[idx] && mism_q != 7'd127)
                mism_q <= mism_q + 7'd1;
`endif
              cnt <= '0;
              if (idx == LAST_IDX) begin
                if (resume_q) begin
                  debug_resume_o <= 1'b1;
                  state          <= S_RESUME;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                idx   <= idx + 6'd1;
                state <= S_REQ;
              end
            end
          end
          S_RESUME: begin
            if (!debug_halted_i) begin
              debug_resume_o <= 1'b0;
              state          <= S_DONE;
            end
          end
          S_DONE: begin
            done_o  <= 1'b1;
            error_o <= err_q;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbg_ctx_sequencer.sv
// tb/tb_dbg_ctx_sequencer.sv - scoreboard bench for dbg_ctx_sequencer with a behavioural debug slave
module tb_dbg_ctx_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic        cmd_resume_i;
  logic        done_o;
  logic        error_o;
  logic [6:0]  mismatch_cnt_o;
  logic [5:0]  ctx_idx_i;
  logic        ctx_we_i;
  logic [31:0] ctx_wdata_i;
  logic [31:0] ctx_rdata_o;
  logic        debug_req_o;
  logic [14:0] debug_addr_o;
  logic        debug_we_o;
  logic [31:0] debug_wdata_o;
  logic        debug_gnt_i;
  logic        debug_rvalid_i;
  logic [31:0] debug_rdata_i;
  logic        debug_halt_o;
  logic        debug_resume_o;
  logic        debug_halted_i;

  always #5 clk = ~clk;

  dbg_ctx_sequencer dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_resume_i(cmd_resume_i),
    .done_o(done_o), .error_o(error_o), .mismatch_cnt_o(mismatch_cnt_o),
    .ctx_idx_i(ctx_idx_i), .ctx_we_i(ctx_we_i), .ctx_wdata_i(ctx_wdata_i), .ctx_rdata_o(ctx_rdata_o),
    .debug_req_o(debug_req_o), .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o), .debug_wdata_o(debug_wdata_o),
    .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i), .debug_rdata_i(debug_rdata_i),
    .debug_halt_o(debug_halt_o), .debug_resume_o(debug_resume_o), .debug_halted_i(debug_halted_i)
  );

  // Debug slave model: zero-wait grant (optionally withheld for register 5), rvalid one cycle after grant,
  // core halts/resumes three cycles after the request.
  logic [31:0] mem [64];
  logic        core_halted = 1'b0;
  logic [1:0]  hcnt = 2'd0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        withhold = 1'b0;
  logic        force_halt = 1'b0;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_data = 32'd0;

  assign debug_gnt_i    = debug_req_o && !(withhold && debug_addr_o == 15'h414);
  assign debug_rvalid_i = rvalid;
  assign debug_rdata_i  = rdata;
  assign debug_halted_i = core_halted;

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (poke_en) mem[poke_idx] <= poke_data;
    if (debug_req_o && debug_gnt_i) begin
      rvalid <= 1'b1;
      rdata  <= mem[debug_addr_o[7:2]];
      if (debug_we_o) mem[debug_addr_o[7:2]] <= debug_wdata_o;
    end
    if (force_halt) begin
      core_halted <= 1'b1;
      hcnt        <= 2'd0;
    end else if ((debug_halt_o && !core_halted) || (debug_resume_o && core_halted)) begin
      hcnt <= hcnt + 2'd1;
      if (hcnt == 2'd2) begin
        core_halted <= !core_halted;
        hcnt        <= 2'd0;
      end
    end else begin
      hcnt <= 2'd0;
    end
  end

  typedef struct packed {
    logic [14:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  int         r_lat, r_halts, r_resumes, r_rise;
  logic       r_err;
  logic [6:0] r_mism;
  bit         r_to, r_req_halt;

  task automatic run_cmd(input logic [1:0] op, input logic res);
    bit   prev_req;
    int   w;
    txn_t t;
    r_lat = 0; r_halts = 0; r_resumes = 0; r_rise = -1; r_err = 1'b0; r_mism = 7'd0; r_to = 0; r_req_halt = 0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready_o && w < 50) begin @(negedge clk); w++; end
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_resume_i = res;
    prev_req = 1'b0;
    do begin
      @(negedge clk);
      cmd_valid_i = 1'b0;
      r_lat++;
      if (debug_halt_o) r_halts++;
      if (debug_resume_o) r_resumes++;
      if (debug_req_o && debug_halt_o) r_req_halt = 1;
      if (debug_req_o && !prev_req) r_rise = r_lat;
      prev_req = debug_req_o;
      if (debug_req_o && debug_gnt_i) begin
        t.addr = debug_addr_o; t.we = debug_we_o; t.wdata = debug_wdata_o;
        obs_q.push_back(t);
      end
    end while (!done_o && r_lat < 3000);
    if (!done_o) r_to = 1;
    r_err  = error_o;
    r_mism = mismatch_cnt_o;
  endtask

  task automatic model_fill(input logic [31:0] base);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); poke_en = 1'b1; poke_idx = 6'(i); poke_data = base + 32'(i);
    end
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic model_poke(input logic [5:0] i, input logic [31:0] d);
    @(negedge clk); poke_en = 1'b1; poke_idx = i; poke_data = d;
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic push_window(input logic we);
    txn_t t;
    for (int i = 0; i < 32; i++) begin
      t.addr = 15'h400 + 15'(4 * i); t.we = we; t.wdata = we ? ~32'(i) : 32'd0;
      exp_q.push_back(t);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cmd_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_in_reset: got %b expected 0", cmd_ready_o); end
    rst_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready_o); end
    tests_run++;
    if ({done_o, error_o, mismatch_cnt_o, debug_req_o, debug_addr_o, debug_we_o, debug_wdata_o, debug_halt_o, debug_resume_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got done=%b err=%b mism=%0d req=%b addr=%h we=%b wdata=%h halt=%b resume=%b expected all 0",
               done_o, error_o, mismatch_cnt_o, debug_req_o, debug_addr_o, debug_we_o, debug_wdata_o, debug_halt_o, debug_resume_o);
    end
  endtask

  task automatic test_save_resume();
    txn_t e, o;
    model_fill(32'hA000_0000);
    obs_q.delete(); exp_q.delete();
    push_window(1'b0);
    run_cmd(2'd0, 1'b1);
    tests_run++;
    if (r_to) begin tests_failed++; $display("FAIL save_done_timeout: got no done expected done"); end
    tests_run++;
    if (r_err !== 1'b0) begin tests_failed++; $display("FAIL save_error: got %b expected 0", r_err); end
    tests_run++;
    if (r_halts == 0 || r_req_halt) begin tests_failed++; $display("FAIL save_halt: got halt cycles %0d overlap %0d expected >0 and 0", r_halts, r_req_halt); end
    tests_run++;
    if (r_resumes == 0 || core_halted !== 1'b0) begin tests_failed++; $display("FAIL save_resume: got resume cycles %0d halted %b expected >0 and 0", r_resumes, core_halted); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("FAIL save_txn: got none expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL save_txn: got %h expected %h", o, e); end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL save_extra_txn: got %0d expected 0", obs_q.size()); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ctx_idx_i = 6'(i); #1;
      tests_run++;
      if (ctx_rdata_o !== 32'hA000_0000 + 32'(i)) begin tests_failed++; $display("FAIL save_ctx[%0d]: got %h expected %h", i, ctx_rdata_o, 32'hA000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_restore_halted();
    txn_t e, o;
    @(negedge clk); force_halt = 1'b1;
    @(negedge clk); force_halt = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ctx_we_i = 1'b1; ctx_idx_i = 6'(i); ctx_wdata_i = ~32'(i);
    end
    @(negedge clk); ctx_we_i = 1'b0;
    obs_q.delete(); exp_q.delete();
    push_window(1'b1);
    run_cmd(2'd1, 1'b0);
    tests_run++;
    if (r_to || r_lat != 98) begin tests_failed++; $display("FAIL restore_latency: got %0d (timeout %0d) expected 98", r_lat, r_to); end
    tests_run++;
    if (r_err !== 1'b0) begin tests_failed++; $display("FAIL restore_error: got %b expected 0", r_err); end
    tests_run++;
    if (r_halts != 0 || r_resumes != 0) begin tests_failed++; $display("FAIL restore_runctl: got halt %0d resume %0d expected 0 0", r_halts, r_resumes); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("FAIL restore_txn: got none expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL restore_txn: got %h expected %h", o, e); end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL restore_extra_txn: got %0d expected 0", obs_q.size()); end
  endtask

`ifdef DBG_SEQ_VERIFY_EN
  task automatic test_verify();
    model_poke(6'd3, 32'h0);
    model_poke(6'd17, 32'h5555_1234);
    obs_q.delete();
    run_cmd(2'd2, 1'b0);
    tests_run++;
    if (r_to || r_lat != 98) begin tests_failed++; $display("FAIL verify_latency: got %0d (timeout %0d) expected 98", r_lat, r_to); end
    tests_run++;
    if (r_err !== 1'b0) begin tests_failed++; $display("FAIL verify_error: got %b expected 0", r_err); end
    tests_run++;
    if (r_mism !== 7'd2) begin tests_failed++; $display("FAIL verify_mismatch: got %0d expected 2", r_mism); end
    tests_run++;
    if (obs_q.size() != 32) begin tests_failed++; $display("FAIL verify_reads: got %0d expected 32", obs_q.size()); end
    obs_q.delete();
  endtask
`endif

  task automatic test_illegal_op(input logic [1:0] op);
    obs_q.delete();
    run_cmd(op, 1'b1);
    tests_run++;
    if (r_to || r_lat != 2) begin tests_failed++; $display("FAIL illegal_op%0d_latency: got %0d (timeout %0d) expected 2", op, r_lat, r_to); end
    tests_run++;
    if (r_err !== 1'b1) begin tests_failed++; $display("FAIL illegal_op%0d_error: got %b expected 1", op, r_err); end
    tests_run++;
    if (obs_q.size() != 0 || r_rise != -1 || r_halts != 0) begin
      tests_failed++; $display("FAIL illegal_op%0d_traffic: got txns %0d halts %0d expected 0 0", op, obs_q.size(), r_halts);
    end
    tests_run++;
    if (mismatch_cnt_o !== 7'd0) begin tests_failed++; $display("FAIL illegal_op%0d_mismatch: got %0d expected 0", op, mismatch_cnt_o); end
  endtask

  task automatic test_timeout();
    txn_t e, o;
    logic [31:0] exp_d;
    model_fill(32'hB000_0000);
    withhold = 1'b1;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      e.addr = 15'h400 + 15'(4 * i); e.we = 1'b0; e.wdata = 32'd0;
      exp_q.push_back(e);
    end
    run_cmd(2'd0, 1'b0);
    tests_run++;
    if (r_to || r_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_error: got %b (timeout %0d) expected 1", r_err, r_to); end
    tests_run++;
    if (r_lat - r_rise != 256) begin tests_failed++; $display("FAIL timeout_latency: got %0d expected 256", r_lat - r_rise); end
    tests_run++;
    if (debug_req_o !== 1'b0) begin tests_failed++; $display("FAIL timeout_req_drop: got %b expected 0", debug_req_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("FAIL timeout_txn: got none expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL timeout_txn: got %h expected %h", o, e); end
      end
    end
    withhold = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ctx_idx_i = 6'(i); #1;
      exp_d = (i < 5) ? 32'hB000_0000 + 32'(i) : ~32'(i);
      tests_run++;
      if (ctx_rdata_o !== exp_d) begin tests_failed++; $display("FAIL timeout_ctx[%0d]: got %h expected %h", i, ctx_rdata_o, exp_d); end
    end
  endtask

  task automatic test_reset_mid();
    int n, w, dones;
    model_fill(32'hC000_0000);
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_resume_i = 1'b0;
    n = 0; w = 0;
    while (n < 11 && w < 500) begin
      @(negedge clk); cmd_valid_i = 1'b0; w++;
      if (debug_req_o && debug_gnt_i) n++;
    end
    tests_run++;
    if (n != 11) begin tests_failed++; $display("FAIL reset_mid_reach: got %0d grants expected 11", n); end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({debug_req_o, debug_addr_o, debug_we_o, debug_wdata_o, debug_halt_o, debug_resume_o, done_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got req=%b addr=%h we=%b halt=%b resume=%b done=%b expected all 0",
               debug_req_o, debug_addr_o, debug_we_o, debug_halt_o, debug_resume_o, done_o);
    end
    rst_i = 1'b0;
    dones = 0;
    repeat (8) begin @(negedge clk); if (done_o) dones++; end
    tests_run++;
    if (dones != 0 || cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_idle: got done %0d ready %b expected 0 1", dones, cmd_ready_o); end
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    run_cmd(2'd0, 1'b0);
    tests_run++;
    if (r_to || r_lat != 98 || r_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_save: got lat %0d err %b expected 98 0", r_lat, r_err); end
    tests_run++;
    if (obs_q.size() != 32) begin tests_failed++; $display("FAIL b2b_reads: got %0d expected 32", obs_q.size()); end
    obs_q.delete();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ctx_idx_i = 6'(i); #1;
      tests_run++;
      if (ctx_rdata_o !== 32'hC000_0000 + 32'(i)) begin tests_failed++; $display("FAIL b2b_ctx[%0d]: got %h expected %h", i, ctx_rdata_o, 32'hC000_0000 + 32'(i)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_resume_i = 1'b0;
    ctx_idx_i = 6'd0; ctx_we_i = 1'b0; ctx_wdata_i = 32'd0;
    test_reset();
    test_save_resume();
    test_restore_halted();
`ifdef DBG_SEQ_VERIFY_EN
    test_verify();
`else
    test_illegal_op(2'd2);
`endif
    test_illegal_op(2'd3);
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
